// File: rtl/board_reveal_ctrl_pkg.sv
// Shared types for the board reveal path: hand ordering, controller states,
// and the per-frame money/player snapshot.
package board_reveal_ctrl_pkg;

    typedef enum logic [2:0] {
        pre_flop = 3'd0,
        flop     = 3'd1,
        turn     = 3'd2,
        river    = 3'd3,
        showdown = 3'd4
    } hand_state_t;

    typedef enum logic {
        IDLE   = 1'b0,
        REVEAL = 1'b1
    } reveal_ctrl_state_t;

    localparam int         MONEY_W     = 11;
    localparam int         NUM_PLAYERS = 2;
    localparam logic [1:0] FLOP_FULL   = 2'd3;

    typedef logic [NUM_PLAYERS-1:0][MONEY_W-1:0] player_money_t;

    typedef struct packed {
        player_money_t      stacks;
        player_money_t      pots;
        logic [MONEY_W-1:0] pot_size;
        logic               current_player;
        logic               current_dealer;
        logic               winner;
    } frame_snap_t;

    // Encoding is declared in street order, so ordering is a plain compare.
    function automatic logic hand_state_ahead(input hand_state_t a, input hand_state_t b);
        return a > b;
    endfunction

endpackage

// File: rtl/frame_pacer.sv
// Counts frames between reveal steps and pulses step_tick on the frame that
// completes a FRAMES_PER_CARD interval.
module frame_pacer #(
    parameter int FRAMES_PER_CARD = 20,
    parameter int FC_W            = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_start,
    input  logic clear,
    input  logic enable,
    output logic step_tick
);

    localparam logic [FC_W-1:0] LAST = FC_W'(FRAMES_PER_CARD - 1);

    logic [FC_W-1:0] frame_cnt;

    assign step_tick = frame_start && enable && !clear && (frame_cnt == LAST);

    // Count stops at LAST and restarts, so it never wraps.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_cnt <= '0;
        end else if (frame_start) begin
            if (clear || step_tick)
                frame_cnt <= '0;
            else if (enable)
                frame_cnt <= frame_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/board_reveal_ctrl.sv
// Frame-synchronous snapshot of game state for game_screen, with community
// cards revealed one step per FRAMES_PER_CARD frames.
module board_reveal_ctrl
    import board_reveal_ctrl_pkg::*;
#(
    parameter int FRAMES_PER_CARD = 20,
    parameter int FC_W            = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_start,
    input  hand_state_t        fsm_state,
    input  player_money_t      fsm_player_stacks,
    input  player_money_t      fsm_player_pots,
    input  logic [MONEY_W-1:0] fsm_pot_size,
    input  logic               fsm_current_player,
    input  logic               fsm_current_dealer,
    input  logic               fsm_winner,
    output hand_state_t        disp_state,
    output logic [1:0]         disp_flop_count,
    output player_money_t      disp_player_stacks,
    output player_money_t      disp_player_pots,
    output logic [MONEY_W-1:0] disp_pot_size,
    output logic               disp_current_player,
    output logic               disp_current_dealer,
    output logic               disp_winner,
    output logic               busy,
    output logic               reveal_done
);

    reveal_ctrl_state_t ctrl_state;
    hand_state_t        target, tgt_now, nxt_state;
    frame_snap_t        snap;
    logic [1:0]         nxt_count;
    logic               behind, ahead, settled, nxt_done, do_step, step_tick, pacer_clear;

    // Decisions on a frame_start use the value being loaded into target.
    assign tgt_now  = frame_start ? fsm_state : target;
    assign behind   = hand_state_ahead(disp_state, tgt_now);
    assign ahead    = hand_state_ahead(tgt_now, disp_state);
    assign settled  = (disp_state == tgt_now) &&
                      (disp_flop_count == FLOP_FULL || disp_state == pre_flop);
    assign nxt_done = (nxt_state == tgt_now) && (nxt_count == FLOP_FULL);
    assign do_step  = (ctrl_state == IDLE) ? ahead : step_tick;

    assign pacer_clear = frame_start &&
                         (ctrl_state == IDLE || behind || settled);

    always_comb begin
        nxt_state = disp_state;
        nxt_count = disp_flop_count;
        case (disp_state)
            pre_flop: begin
                nxt_state = flop;
                nxt_count = 2'd1;
            end
            flop: begin
                if (disp_flop_count != FLOP_FULL) nxt_count = disp_flop_count + 2'd1;
                else                              nxt_state = turn;
            end
            turn:    nxt_state = river;
            river:   nxt_state = showdown;
            default: ;
        endcase
    end

    frame_pacer #(
        .FRAMES_PER_CARD(FRAMES_PER_CARD),
        .FC_W           (FC_W)
    ) u_pacer (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_start(frame_start),
        .clear      (pacer_clear),
        .enable     (ctrl_state == REVEAL),
        .step_tick  (step_tick)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ctrl_state      <= IDLE;
            target          <= pre_flop;
            disp_state      <= pre_flop;
            disp_flop_count <= '0;
            snap            <= '0;
            busy            <= 1'b0;
            reveal_done     <= 1'b0;
        end else begin
            reveal_done <= 1'b0;
            if (frame_start) begin
                target <= fsm_state;
                snap   <= '{stacks: fsm_player_stacks, pots: fsm_player_pots,
                            pot_size: fsm_pot_size, current_player: fsm_current_player,
                            current_dealer: fsm_current_dealer, winner: fsm_winner};
                if (behind) begin
                    disp_state      <= tgt_now;
                    disp_flop_count <= (tgt_now == pre_flop) ? 2'd0 : FLOP_FULL;
                    busy            <= 1'b0;
                    ctrl_state      <= IDLE;
                end else if (ctrl_state == REVEAL && settled) begin
                    // Target pulled back onto the street already on screen.
                    busy        <= 1'b0;
                    ctrl_state  <= IDLE;
                    reveal_done <= 1'b1;
                end else if (do_step) begin
                    disp_state      <= nxt_state;
                    disp_flop_count <= nxt_count;
                    if (nxt_done) begin
                        busy        <= 1'b0;
                        ctrl_state  <= IDLE;
                        reveal_done <= 1'b1;
                    end else begin
                        busy       <= 1'b1;
                        ctrl_state <= REVEAL;
                    end
                end
            end
        end
    end

    assign disp_player_stacks  = snap.stacks;
    assign disp_player_pots    = snap.pots;
    assign disp_pot_size       = snap.pot_size;
    assign disp_current_player = snap.current_player;
    assign disp_current_dealer = snap.current_dealer;
    assign disp_winner         = snap.winner;

endmodule

// File: tb/tb_board_reveal_ctrl.sv
// Three controllers (FRAMES_PER_CARD = 3, 2, 1) share one stimulus stream and
// are checked every cycle against a position-based reveal model.
module tb_board_reveal_ctrl;
    import board_reveal_ctrl_pkg::*;

    localparam int N = 3;

    logic               Clk = 1'b0, Reset = 1'b1, frame_start = 1'b0;
    hand_state_t        fsm_state = pre_flop;
    player_money_t      fsm_player_stacks = '0, fsm_player_pots = '0;
    logic [MONEY_W-1:0] fsm_pot_size = '0;
    logic               fsm_current_player = 1'b0, fsm_current_dealer = 1'b0, fsm_winner = 1'b0;

    hand_state_t        d_state [N];
    logic [1:0]         d_cnt   [N];
    player_money_t      d_stacks[N], d_pots[N];
    logic [MONEY_W-1:0] d_pot   [N];
    logic               d_pl[N], d_dl[N], d_win[N], d_busy[N], d_done[N];

    always #5 Clk = ~Clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        board_reveal_ctrl #(.FRAMES_PER_CARD(3 - g), .FC_W(8)) u_dut (
            .Clk                (Clk),
            .Reset              (Reset),
            .frame_start        (frame_start),
            .fsm_state          (fsm_state),
            .fsm_player_stacks  (fsm_player_stacks),
            .fsm_player_pots    (fsm_player_pots),
            .fsm_pot_size       (fsm_pot_size),
            .fsm_current_player (fsm_current_player),
            .fsm_current_dealer (fsm_current_dealer),
            .fsm_winner         (fsm_winner),
            .disp_state         (d_state[g]),
            .disp_flop_count    (d_cnt[g]),
            .disp_player_stacks (d_stacks[g]),
            .disp_player_pots   (d_pots[g]),
            .disp_pot_size      (d_pot[g]),
            .disp_current_player(d_pl[g]),
            .disp_current_dealer(d_dl[g]),
            .disp_winner        (d_win[g]),
            .busy               (d_busy[g]),
            .reveal_done        (d_done[g])
        );
    end

    int nvec = 0, nerr = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input int k, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s[dut%0d] at %0t: got %0d, need %0d", nm, k, $time, act, exp);
        end
    endtask

    // Model: the display is a position 0..6 along the reveal walk.
    function automatic int fpc_of(input int k);
        return 3 - k;
    endfunction

    function automatic int rank(input hand_state_t s);
        case (s)
            pre_flop: return 0;
            flop:     return 1;
            turn:     return 2;
            river:    return 3;
            default:  return 4;
        endcase
    endfunction

    function automatic int pos_of(input hand_state_t s);
        case (s)
            pre_flop: return 0;
            flop:     return 3;
            turn:     return 4;
            river:    return 5;
            default:  return 6;
        endcase
    endfunction

    function automatic hand_state_t state_at(input int p);
        if (p == 0) return pre_flop;
        if (p <= 3) return flop;
        if (p == 4) return turn;
        if (p == 5) return river;
        return showdown;
    endfunction

    function automatic int cnt_at(input int p);
        return (p < 3) ? p : 3;
    endfunction

    int            m_pos[N], m_since[N];
    bit            m_busy[N], m_done[N];
    player_money_t e_stacks = '0, e_pots = '0;
    int            e_pot = 0;
    bit            e_pl = 1'b0, e_dl = 1'b0, e_win = 1'b0;

    always @(posedge Clk) begin
        for (int k = 0; k < N; k++) begin
            int p, s, tp;
            bit b, d;
            p = m_pos[k]; s = m_since[k]; b = m_busy[k]; d = 1'b0;
            tp = pos_of(fsm_state);
            if (Reset) begin
                p = 0; s = 0; b = 1'b0;
            end else if (frame_start) begin
                if (rank(fsm_state) < rank(state_at(p))) begin
                    p = tp; s = 0; b = 1'b0;
                end else if (!b) begin
                    if (tp > p) begin
                        p++; s = 0;
                        if (p == tp) d = 1'b1; else b = 1'b1;
                    end
                end else if (p >= tp) begin
                    b = 1'b0; d = 1'b1;
                end else begin
                    s++;
                    if (s == fpc_of(k)) begin
                        p++; s = 0;
                        if (p == tp) begin b = 1'b0; d = 1'b1; end
                    end
                end
            end
            m_pos[k] <= p; m_since[k] <= s; m_busy[k] <= b; m_done[k] <= d;
        end
        if (Reset) begin
            e_stacks <= '0; e_pots <= '0; e_pot <= 0; e_pl <= 1'b0; e_dl <= 1'b0; e_win <= 1'b0;
        end else if (frame_start) begin
            e_stacks <= fsm_player_stacks; e_pots <= fsm_player_pots; e_pot <= int'(fsm_pot_size);
            e_pl <= fsm_current_player; e_dl <= fsm_current_dealer; e_win <= fsm_winner;
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            for (int k = 0; k < N; k++) begin
                chk("state",  k, int'(d_state[k]), int'(state_at(m_pos[k])));
                chk("flops",  k, int'(d_cnt[k]),   cnt_at(m_pos[k]));
                chk("busy",   k, int'(d_busy[k]),  int'(m_busy[k]));
                chk("done",   k, int'(d_done[k]),  int'(m_done[k]));
                chk("stacks", k, int'(d_stacks[k]), int'(e_stacks));
                chk("pots",   k, int'(d_pots[k]),  int'(e_pots));
                chk("pot",    k, int'(d_pot[k]),   e_pot);
                chk("pdw",    k, int'({d_pl[k], d_dl[k], d_win[k]}), int'({e_pl, e_dl, e_win}));
            end
        end
    end

    bit fs_q = 1'b0;
    always @(posedge Clk) begin
        assert (!(frame_start && fs_q)) else $error("frame_start held high two cycles");
        fs_q <= frame_start;
    end

    // One frame pulse; done_seen captures reveal_done in the cycle after it.
    task automatic frame(output logic [N-1:0] done_seen);
        frame_start = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
        for (int k = 0; k < N; k++) done_seen[k] = d_done[k];
        repeat (2) @(negedge Clk);
    endtask

    logic [N-1:0] ds;

    initial begin
        repeat (2) @(negedge Clk);
        chk_en = 1'b1;
        for (int k = 0; k < N; k++) begin
            chk("rst_state", k, int'(d_state[k]), int'(pre_flop));
            chk("rst_flops", k, int'(d_cnt[k]), 0);
            chk("rst_busy",  k, int'(d_busy[k]), 0);
        end
        Reset = 1'b0;
        @(negedge Clk);

        // Basic flop reveal
        fsm_pot_size = 11'd40;
        fsm_player_stacks = {11'd480, 11'd500};
        fsm_player_pots = {11'd20, 11'd20};
        fsm_current_dealer = 1'b1;
        fsm_state = flop;
        for (int f = 1; f <= 7; f++) begin
            frame(ds);
            if (f == 1) begin
                chk("flop_f1_cnt", 0, int'(d_cnt[0]), 1);
                chk("flop_f1_busy", 0, int'(d_busy[0]), 1);
                chk("flop_f1_pot", 0, int'(d_pot[0]), 40);
            end
            if (f == 3) begin
                chk("flop_f3_cnt", 0, int'(d_cnt[0]), 1);
                chk("flop_fpc1_done", 2, int'(ds[2]), 1);
            end
            if (f == 4) begin
                chk("flop_f4_cnt", 0, int'(d_cnt[0]), 2);
                chk("flop_f4_done", 0, int'(ds[0]), 0);
            end
            if (f == 6) chk("flop_f6_cnt", 0, int'(d_cnt[0]), 2);
            if (f == 7) begin
                chk("flop_f7_cnt", 0, int'(d_cnt[0]), 3);
                chk("flop_f7_done", 0, int'(ds[0]), 1);
                chk("flop_f7_busy", 0, int'(d_busy[0]), 0);
            end
        end

        // Snapshot isolation
        fsm_pot_size = 11'd90;
        repeat (3) @(negedge Clk);
        chk("iso_hold90", 0, int'(d_pot[0]), 40);
        fsm_pot_size = 11'd150;
        repeat (2) @(negedge Clk);
        chk("iso_hold150", 0, int'(d_pot[0]), 40);
        frame(ds);
        chk("iso_new", 0, int'(d_pot[0]), 150);

        // New hand mid-reveal
        fsm_state = pre_flop;
        frame(ds);
        chk("nh_snap", 0, int'(d_state[0]), int'(pre_flop));
        fsm_state = flop;
        for (int f = 1; f <= 4; f++) frame(ds);
        chk("nh_f4_cnt", 0, int'(d_cnt[0]), 2);
        chk("nh_f4_busy", 0, int'(d_busy[0]), 1);
        fsm_state = pre_flop;
        fsm_winner = 1'b1;
        frame(ds);
        chk("nh_state", 0, int'(d_state[0]), int'(pre_flop));
        chk("nh_cnt",   0, int'(d_cnt[0]), 0);
        chk("nh_busy",  0, int'(d_busy[0]), 0);
        chk("nh_done",  0, int'(ds[0]), 0);

        // All-in jump
        fsm_state = showdown;
        fsm_player_stacks = {11'd0, 11'd0};
        fsm_pot_size = 11'd1000;
        for (int f = 1; f <= 16; f++) begin
            frame(ds);
            if (f == 6)  chk("allin_fpc1_done", 2, int'(ds[2]), 1);
            if (f == 10) begin
                chk("allin_f10_state", 1, int'(d_state[1]), int'(river));
                chk("allin_f10_busy",  1, int'(d_busy[1]), 1);
            end
            if (f == 11) begin
                chk("allin_f11_state", 1, int'(d_state[1]), int'(showdown));
                chk("allin_f11_done",  1, int'(ds[1]), 1);
            end
            if (f == 16) chk("allin_fpc3_done", 0, int'(ds[0]), 1);
        end

        // Minimum pacing
        fsm_state = pre_flop;
        frame(ds);
        fsm_state = turn;
        for (int f = 1; f <= 4; f++) begin
            frame(ds);
            if (f < 4) chk("min_busy", 2, int'(d_busy[2]), 1);
            if (f == 2) chk("min_f2_cnt", 2, int'(d_cnt[2]), 2);
            if (f == 4) begin
                chk("min_f4_busy",  2, int'(d_busy[2]), 0);
                chk("min_f4_state", 2, int'(d_state[2]), int'(turn));
                chk("min_f4_done",  2, int'(ds[2]), 1);
            end
        end

        // Target moves ahead mid-reveal
        fsm_state = pre_flop;
        frame(ds);
        fsm_state = flop;
        repeat (2) frame(ds);
        fsm_state = river;
        for (int f = 0; f < 12; f++) frame(ds);

        // Reset together with frame_start mid-reveal
        fsm_state = pre_flop;
        frame(ds);
        fsm_state = river;
        repeat (2) frame(ds);
        Reset = 1'b1;
        frame_start = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        frame_start = 1'b0;
        chk("rstmid_state", 0, int'(d_state[0]), int'(pre_flop));
        chk("rstmid_cnt",   0, int'(d_cnt[0]), 0);
        chk("rstmid_busy",  0, int'(d_busy[0]), 0);
        chk("rstmid_done",  0, int'(d_done[0]), 0);
        chk("rstmid_pot",   0, int'(d_pot[0]), 0);
        repeat (3) @(negedge Clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
